// File: rtl/risc8_pfq_biu.sv
// risc8 bus-interface unit: arbitrates interrupt-ack, data and prefetch
// cycles on one external bus and fills a circular prefetch queue.
module risc8_pfq_biu #(
  parameter int            AW       = 16,
  parameter int            DW       = 8,
  parameter int            QDEPTH   = 4,
  parameter int            MAX_WAIT = 15,
  parameter logic [AW-1:0] RESET_PC = '0,
  localparam int           QCW      = $clog2(QDEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           cycle,
  output logic           write,
  output logic           ifetch,
  output logic           iack,
  output logic [AW-1:0]  address,
  output logic [DW-1:0]  data_out,
  input  logic [DW-1:0]  data_in,
  input  logic           ready,
  output logic           bus_timeout,
  input  logic           q_pop,
  input  logic           q_flush,
  input  logic [AW-1:0]  flush_addr,
  output logic [DW-1:0]  q_out,
  output logic [QCW-1:0] q_count,
  input  logic           d_req,
  input  logic           d_write,
  input  logic [AW-1:0]  d_addr,
  input  logic [DW-1:0]  d_wdata,
  output logic           d_ack,
  input  logic           ia_req,
  output logic           ia_ack,
  output logic [DW-1:0]  d_rdata
);

  localparam int PW  = $clog2(QDEPTH);
  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DATA, IACK} state_t;

  state_t         state, state_next;
  logic [AW-1:0]  fetch_ptr, ptr_next, addr_q;
  logic           wr_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  mem [QDEPTH];
  logic [PW-1:0]  head, tail;
  logic [QCW-1:0] count, count_next;
  logic [WCW-1:0] wait_cnt;
  logic           drop_q;
  logic           tmo, done, start, push, pop_ok, can_fetch, ia_ok, d_ok;
  logic [DW-1:0]  rx_data;

  assign tmo     = (MAX_WAIT != 0) && (state != IDLE) && !ready &&
                   (int'(wait_cnt) == MAX_WAIT - 1);
  assign done    = (state != IDLE) && (ready || tmo);
  assign rx_data = tmo ? '1 : data_in;

  assign pop_ok     = q_pop && (count != '0);
  assign push       = done && (state == FETCH) && !drop_q && !q_flush;
  assign count_next = count + QCW'(push) - QCW'(pop_ok);
  assign can_fetch  = !q_flush && (count_next < QCW'(QDEPTH));
  assign ptr_next   = q_flush ? flush_addr : (push ? fetch_ptr + AW'(1) : fetch_ptr);

  // A request is still held high on its completion edge and while its ack
  // is visible; masking it there prevents a duplicate grant.
  assign ia_ok = ia_req && !ia_ack && !(done && (state == IACK));
  assign d_ok  = d_req && !d_ack && !(done && (state == DATA));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if ((state == IDLE) || done) begin
      if (ia_ok)          state_next = IACK;
      else if (d_ok)      state_next = DATA;
      else if (can_fetch) state_next = FETCH;
      else                state_next = IDLE;
    end
  end

  assign start = ((state == IDLE) || done) && (state_next != IDLE);

  always_comb begin
    cycle    = (state != IDLE);
    ifetch   = (state == FETCH);
    iack     = (state == IACK);
    write    = (state == DATA) && wr_q;
    address  = addr_q;
    data_out = ((state == DATA) && wr_q) ? wdata_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (start) begin
      unique case (state_next)
        FETCH: begin
          addr_q  <= ptr_next;
          wr_q    <= 1'b0;
          wdata_q <= '0;
        end
        DATA: begin
          addr_q  <= d_addr;
          wr_q    <= d_write;
          wdata_q <= d_write ? d_wdata : '0;
        end
        default: begin
          addr_q  <= '0;
          wr_q    <= 1'b0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ptr   <= RESET_PC;
      wait_cnt    <= '0;
      drop_q      <= 1'b0;
      d_rdata     <= '0;
      d_ack       <= 1'b0;
      ia_ack      <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      fetch_ptr   <= ptr_next;
      d_ack       <= done && (state == DATA);
      ia_ack      <= done && (state == IACK);
      bus_timeout <= tmo;
      if (start || done)                     wait_cnt <= '0;
      else if ((state != IDLE) && !ready)    wait_cnt <= wait_cnt + WCW'(1);
      // A fetch still on the bus after a flush must not land in the new queue.
      if (q_flush && (state == FETCH) && !done) drop_q <= 1'b1;
      else if (done)                            drop_q <= 1'b0;
      if (done && ((state == IACK) || ((state == DATA) && !wr_q)))
        d_rdata <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)   tail <= tail + PW'(1);
      if (pop_ok) head <= head + PW'(1);
      count <= count_next;
    end
  end

  // NOTE: queue storage has no reset; q_count gates every read, so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= rx_data;
  end

  assign q_out   = (count == '0) ? '0 : mem[head];
  assign q_count = count;

endmodule

// File: tb/tb_risc8_pfq_biu.sv
// Randomized scoreboard bench for risc8_pfq_biu: a bus responder, three
// request drivers, and a transaction-level model of the fetch stream and queue.
module tb_risc8_pfq_biu;

  localparam int AW       = 16;
  localparam int DW       = 8;
  localparam int QDEPTH   = 4;
  localparam int MAX_WAIT = 15;
  localparam int QCW      = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cycle, write, ifetch, iack, bus_timeout, d_ack, ia_ack;
  logic [AW-1:0]  address;
  logic [DW-1:0]  data_out, q_out, d_rdata;
  logic [QCW-1:0] q_count;
  logic [DW-1:0]  data_in;
  logic           ready;
  logic           q_pop, q_flush;
  logic [AW-1:0]  flush_addr;
  logic           d_req, d_write, ia_req;
  logic [AW-1:0]  d_addr;
  logic [DW-1:0]  d_wdata;

  risc8_pfq_biu #(
    .AW(AW), .DW(DW), .QDEPTH(QDEPTH), .MAX_WAIT(MAX_WAIT), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cycle(cycle), .write(write), .ifetch(ifetch),
    .iack(iack), .address(address), .data_out(data_out), .data_in(data_in),
    .ready(ready), .bus_timeout(bus_timeout), .q_pop(q_pop), .q_flush(q_flush),
    .flush_addr(flush_addr), .q_out(q_out), .q_count(q_count), .d_req(d_req),
    .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .ia_req(ia_req), .ia_ack(ia_ack), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NONE, K_FETCH, K_DATA, K_IACK} kind_e;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } dreq_t;
  typedef struct { logic chk; logic [DW-1:0] val; } rexp_t;

  dreq_t         dreq_q[$];
  rexp_t         rexp_q[$];
  logic [DW-1:0] model_q[$];
  logic [AW-1:0] exp_fetch;
  bit            ia_pend, d_pend, stop_req, stop_bus, flush_done;
  bit            exp_dack, exp_iaack, exp_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bus_data(input logic [AW-1:0] a);
    return 8'h10 + a[7:0];
  endfunction

  // Bus responder and reference model: updates the model on each edge and
  // checks which cycle the DUT opened against the priority rules.
  initial begin : bus_model
    kind_e         exp_kind, cur_kind;
    bit            active, arb, comp, tmo_hit, dropped, pop_now;
    int            elapsed, waits;
    logic [AW-1:0] cyc_addr;
    logic          cyc_wr;
    dreq_t         rq;
    rexp_t         re;
    exp_kind = K_NONE; cur_kind = K_NONE;
    active = 0; arb = 0; dropped = 0; elapsed = 0; waits = 0;
    cyc_addr = '0; cyc_wr = 0;
    ready = 0; data_in = '0; exp_fetch = 16'h0000;
    wait (rst_n === 1'b1);
    while (!stop_bus) begin
      @(posedge clk);
      comp = 0; tmo_hit = 0;
      if (active) begin
        if (cur_kind == K_FETCH && q_flush) dropped = 1;
        if (ready) comp = 1;
        else begin
          elapsed++;
          if (MAX_WAIT > 0 && elapsed == MAX_WAIT) begin comp = 1; tmo_hit = 1; end
        end
      end
      exp_tmo   = tmo_hit;
      exp_dack  = comp && cur_kind == K_DATA;
      exp_iaack = comp && cur_kind == K_IACK;
      if (comp && cur_kind != K_FETCH) begin
        re.chk = !(cur_kind == K_DATA && cyc_wr);
        re.val = tmo_hit ? 8'hFF : bus_data(cyc_addr);
        rexp_q.push_back(re);
      end
      pop_now = q_pop && model_q.size() > 0;
      if (q_flush) begin
        model_q.delete();
        exp_fetch = flush_addr;
      end else begin
        if (pop_now) void'(model_q.pop_front());
        if (comp && cur_kind == K_FETCH && !dropped)
          model_q.push_back(tmo_hit ? 8'hFF : bus_data(cyc_addr));
      end
      arb = !active || comp;
      if (comp) active = 0;
      if (arb)
        exp_kind = ia_pend ? K_IACK : d_pend ? K_DATA :
                   (!q_flush && model_q.size() < QDEPTH) ? K_FETCH : K_NONE;

      @(negedge clk);
      if (arb) begin
        check("arb_cycle", 32'(cycle), 32'(exp_kind != K_NONE));
        if (cycle) begin
          cur_kind = iack ? K_IACK : ifetch ? K_FETCH : K_DATA;
          check("arb_kind", 32'(cur_kind), 32'(exp_kind));
          active = 1; elapsed = 0; dropped = 0;
          cyc_addr = address; cyc_wr = write;
          waits = ($urandom_range(0, 11) == 0) ? 1000 : int'($urandom_range(0, 3));
          case (cur_kind)
            K_IACK: begin
              ia_pend = 0;
              check("iack_addr", 32'(address), 32'h0);
              check("iack_wr", 32'({write, data_out}), 32'h0);
            end
            K_FETCH: begin
              check("fetch_addr", 32'(address), 32'(exp_fetch));
              check("fetch_wr", 32'({write, data_out}), 32'h0);
              exp_fetch++;
            end
            default: begin
              d_pend = 0;
              check("data_req_pending", 32'(dreq_q.size()), 32'd1);
              if (dreq_q.size() > 0) begin
                rq = dreq_q.pop_front();
                check("data_addr", 32'(address), 32'(rq.addr));
                check("data_write", 32'(write), 32'(rq.wr));
                check("data_out", 32'(data_out), 32'(rq.wr ? rq.wdata : 8'h00));
              end
            end
          endcase
        end
      end else begin
        check("cycle_hold", 32'({cycle, address}), 32'({1'b1, cyc_addr}));
      end
      ready   = active && elapsed >= waits;
      data_in = ready ? bus_data(cyc_addr) : DW'($urandom);
    end
    ready = 0;
    data_in = '0;
  end

  // Monitor: compares handshakes, read data and queue state each clock.
  initial begin : monitor
    rexp_t r;
    wait (rst_n === 1'b1);
    while (!stop_bus) begin
      @(negedge clk);
      check("d_ack", 32'(d_ack), 32'(exp_dack));
      check("ia_ack", 32'(ia_ack), 32'(exp_iaack));
      check("bus_timeout", 32'(bus_timeout), 32'(exp_tmo));
      if (d_ack || ia_ack) begin
        check("ack_has_expect", 32'(rexp_q.size() != 0), 32'd1);
        if (rexp_q.size() != 0) begin
          r = rexp_q.pop_front();
          if (r.chk) check("d_rdata", 32'(d_rdata), 32'(r.val));
        end
      end
      check("q_count", 32'(q_count), 32'(model_q.size()));
      check("q_out", 32'(q_out), 32'(model_q.size() != 0 ? model_q[0] : 8'h00));
    end
  end

  initial begin : d_driver
    dreq_t rq;
    int    guard;
    d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    wait (rst_n === 1'b1);
    while (!stop_req) begin
      repeat ($urandom_range(1, 12)) @(posedge clk);
      #2;
      rq.wr    = 1'($urandom_range(0, 1));
      rq.addr  = ($urandom_range(0, 3) == 0) ? 16'h8000 : AW'($urandom);
      rq.wdata = DW'($urandom);
      dreq_q.push_back(rq);
      d_pend = 1;
      d_req = 1; d_write = rq.wr; d_addr = rq.addr; d_wdata = rq.wdata;
      guard = 0;
      while (d_ack !== 1'b1 && guard < 200) begin
        @(posedge clk); #2;
        guard++;
      end
      check("d_ack_in_time", 32'(guard < 200), 32'd1);
      d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    end
  end

  initial begin : ia_driver
    int guard;
    ia_req = 0;
    wait (rst_n === 1'b1);
    while (!stop_req) begin
      repeat ($urandom_range(5, 40)) @(posedge clk);
      #2;
      ia_pend = 1;
      ia_req  = 1;
      guard = 0;
      while (ia_ack !== 1'b1 && guard < 200) begin
        @(posedge clk); #2;
        guard++;
      end
      check("ia_ack_in_time", 32'(guard < 200), 32'd1);
      ia_req = 0;
    end
  end

  // Core side: random pops and flushes, then one flush used by the final
  // asynchronous-reset scenario.
  initial begin : core_driver
    q_pop = 0; q_flush = 0; flush_addr = '0;
    wait (rst_n === 1'b1);
    while (!stop_req) begin
      @(posedge clk); #2;
      q_pop   = ($urandom_range(0, 2) == 0);
      q_flush = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 2))
        0:       flush_addr = 16'h1234;
        1:       flush_addr = 16'hFFFF;
        default: flush_addr = AW'($urandom);
      endcase
    end
    @(posedge clk); #2;
    q_pop = 0; q_flush = 0;
    wait (stop_bus);
    @(posedge clk); #2;
    q_flush = 1; flush_addr = 16'h0100;
    @(posedge clk); #2;
    q_flush = 0;
    flush_done = 1;
  end

  initial begin : main
    rst_n = 1'b0;
    #2;
    check("rst_bus", 32'({cycle, write, ifetch, iack}), 32'h0);
    check("rst_address", 32'(address), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_acks", 32'({d_ack, ia_ack, bus_timeout}), 32'h0);
    check("rst_q", 32'({q_count, q_out}), 32'h0);
    check("rst_d_rdata", 32'(d_rdata), 32'h0);
    #30 rst_n = 1'b1;
    repeat (4000) @(posedge clk);
    stop_req = 1;
    repeat (400) @(posedge clk);
    stop_bus = 1;
    wait (flush_done);
    @(posedge clk); #2;
    check("refetch_after_flush", 32'({cycle, ifetch, address}), 32'({2'b11, 16'h0100}));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_cycle", 32'({cycle, ifetch}), 32'h0);
    check("async_rst_q", 32'(q_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
